// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-client memory arbiter.
// Holds the FSM state encoding, the client identifiers used by the
// round-robin pointer, and a helper that names the opposite client.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_D = 2'b01,
    GRANT_I = 2'b10
  } arb_state_e;

  localparam logic CLIENT_D = 1'b0;
  localparam logic CLIENT_I = 1'b1;

  // The client that should be favoured after `id` has been served.
  function automatic logic other_client(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache clients, the arbiter and the block memory.
//   d_*   : data-cache side (read/write requests, busywait, read block)
//   i_*   : instruction-cache side (read requests only)
//   mem_* : block memory side (strobes, address/data, busywait)
// Modports:
//   slave  : the arbiter's view (takes client requests and memory responses)
//   master : the environment's view (caches + memory driving the arbiter)
interface mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_busywait;

  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  modport slave (
    input  d_read, d_write, d_address, d_writedata,
    output d_readdata, d_busywait,
    input  i_read, i_address,
    output i_readdata, i_busywait,
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport master (
    output d_read, d_write, d_address, d_writedata,
    input  d_readdata, d_busywait,
    output i_read, i_address,
    input  i_readdata, i_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
//   req_d, req_i : pending requests from the data and instruction caches
//   rr_ptr       : client favoured when both request (0 = D, 1 = I)
//   grant_valid  : at least one client is requesting
//   grant_id     : client to grant (meaningful only when grant_valid = 1)
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic req_d,
  input  logic req_i,
  input  logic rr_ptr,
  output logic grant_valid,
  output logic grant_id
);

  // Lone requester wins outright; a tie goes to the pointer's client.
  always_comb begin
    grant_valid = req_d | req_i;
    if (req_d && req_i) begin
      grant_id = rr_ptr;
    end else if (req_i) begin
      grant_id = CLIENT_I;
    end else begin
      grant_id = CLIENT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block memory between the data cache (D) and the instruction
// cache (I). One memory transaction is granted at a time, round-robin on
// ties; the grant is held until memory completes, and the waiting client is
// stalled through its busywait.
//   clk : system clock, posedge active
//   rst : asynchronous, active-high reset
//   bus : mem_arbiter_if.slave (client requests/responses, memory strobes)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_if.slave    bus
);

  arb_state_e        state_r;
  logic              started_r;
  logic              rr_ptr_r;
  logic [ADDR_W-1:0] addr_hold_r;
  logic [DATA_W-1:0] wdata_hold_r;

  logic              req_d_s;
  logic              req_i_s;
  logic              grant_valid_s;
  logic              grant_id_s;
  logic              done_s;
  logic              mem_read_s;
  logic              mem_write_s;
  logic [ADDR_W-1:0] mem_address_s;
  logic [DATA_W-1:0] mem_writedata_s;

  assign req_d_s = bus.d_read | bus.d_write;
  assign req_i_s = bus.i_read;

  // Memory has acknowledged the access (busy seen) and has now finished it.
  assign done_s = started_r & ~bus.mem_busywait;

  rr_pick2 u_pick (
    .req_d       (req_d_s),
    .req_i       (req_i_s),
    .rr_ptr      (rr_ptr_r),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Grant FSM plus the address/data hold registers shown on the bus in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      started_r    <= 1'b0;
      rr_ptr_r     <= CLIENT_D;
      addr_hold_r  <= {ADDR_W{1'b0}};
      wdata_hold_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          started_r <= 1'b0;
          if (grant_valid_s) begin
            state_r <= (grant_id_s == CLIENT_I) ? GRANT_I : GRANT_D;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT_D: begin
          addr_hold_r  <= bus.d_address;
          wdata_hold_r <= bus.d_writedata;
          if (done_s) begin
            state_r   <= IDLE;
            started_r <= 1'b0;
            rr_ptr_r  <= other_client(CLIENT_D);
          end else if (!started_r && !req_d_s) begin
            // Request withdrawn before memory picked it up: no turn consumed.
            state_r <= IDLE;
          end else if (bus.mem_busywait) begin
            started_r <= 1'b1;
          end else begin
            started_r <= started_r;
          end
        end
        GRANT_I: begin
          addr_hold_r <= bus.i_address;
          if (done_s) begin
            state_r   <= IDLE;
            started_r <= 1'b0;
            rr_ptr_r  <= other_client(CLIENT_I);
          end else if (!started_r && !req_i_s) begin
            state_r <= IDLE;
          end else if (bus.mem_busywait) begin
            started_r <= 1'b1;
          end else begin
            started_r <= started_r;
          end
        end
        default: begin
          state_r   <= IDLE;
          started_r <= 1'b0;
        end
      endcase
    end
  end

  // Route the granted client onto the memory bus; IDLE replays the held values.
  always_comb begin
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    mem_address_s   = addr_hold_r;
    mem_writedata_s = wdata_hold_r;
    case (state_r)
      GRANT_D: begin
        // A simultaneous read and write from D is treated as a write.
        mem_write_s     = bus.d_write;
        mem_read_s      = bus.d_read & ~bus.d_write;
        mem_address_s   = bus.d_address;
        mem_writedata_s = bus.d_writedata;
      end
      GRANT_I: begin
        mem_read_s    = bus.i_read;
        mem_address_s = bus.i_address;
      end
      default: begin
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
      end
    endcase
  end

  // Strobes are cut in the completion cycle so memory never sees a repeat.
  assign bus.mem_read      = mem_read_s & ~done_s;
  assign bus.mem_write     = mem_write_s & ~done_s;
  assign bus.mem_address   = mem_address_s;
  assign bus.mem_writedata = mem_writedata_s;

  assign bus.d_busywait = req_d_s & ~((state_r == GRANT_D) & done_s);
  assign bus.i_busywait = req_i_s & ~((state_r == GRANT_I) & done_s);
  assign bus.d_readdata = bus.mem_readdata;
  assign bus.i_readdata = bus.mem_readdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();
  mem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks   = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] init_val(input int i);
    if (i == 5) return 32'hDEADBEEF;
    return 32'hC0DE0000 | 32'(i);
  endfunction

  // ---------------- memory model: busy for 5 cycles per access ----------------
  logic [31:0] mem_model [64];
  int          mem_cnt = 0;
  logic        mem_op_wr;
  logic [5:0]  mem_op_addr;
  logic [31:0] mem_op_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cnt <= 0;
      bus.mem_busywait <= 1'b0;
      bus.mem_readdata <= 32'h0;
      for (int i = 0; i < 64; i++) mem_model[i] <= init_val(i);
    end else if (mem_cnt > 0) begin
      mem_cnt <= mem_cnt - 1;
      if (mem_cnt == 1) begin
        bus.mem_busywait <= 1'b0;
        if (mem_op_wr) mem_model[mem_op_addr] <= mem_op_data;
        else bus.mem_readdata <= mem_model[mem_op_addr];
      end
    end else if (bus.mem_read || bus.mem_write) begin
      mem_cnt <= 5;
      bus.mem_busywait <= 1'b1;
      mem_op_wr   <= bus.mem_write;
      mem_op_addr <= bus.mem_address;
      mem_op_data <= bus.mem_writedata;
    end
  end

  // Flags any cycle where memory sees both strobes together.
  logic dual_strobe_seen = 1'b0;
  always @(negedge clk) begin
    if (bus.mem_read && bus.mem_write) dual_strobe_seen <= 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] ref_mem [64];
  int          expect_next = -1;   // client that must be served next, -1 = free
  int          log_id[$];
  logic [5:0]  log_addr[$];

  // Once a client finishes while the other is waiting, the other goes next.
  function automatic void note_done(input int id, input logic other_req, input logic [5:0] a);
    if (expect_next >= 0) check("rr_order", 32'(id), 32'(expect_next));
    expect_next = other_req ? 1 - id : -1;
    log_id.push_back(id);
    log_addr.push_back(a);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = 6'h0; bus.d_writedata = 32'h0;
    bus.i_read = 1'b0; bus.i_address = 6'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    expect_next = -1;
    log_id.delete();
    log_addr.delete();
  endtask

  // One D transaction; entered just after a posedge, returns just after one.
  task automatic d_txn(input logic rd, input logic wr, input logic [5:0] a, input logic [31:0] wd);
    bit done = 1'b0;
    bus.d_read = rd; bus.d_write = wr; bus.d_address = a; bus.d_writedata = wd;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (bus.d_busywait == 1'b0) done = 1'b1;
    end
    if (!done) begin
      check("d_timeout", 32'h0, 32'h1);
    end else begin
      check("d_gate", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
      if (rd && !wr) check("d_rdata", bus.d_readdata, ref_mem[a]);
      if (wr) ref_mem[a] = wd;
      note_done(0, bus.i_read, a);
    end
    @(posedge clk); #1;
    bus.d_read = 1'b0; bus.d_write = 1'b0;
  endtask

  task automatic i_txn(input logic [5:0] a);
    bit done = 1'b0;
    bus.i_read = 1'b1; bus.i_address = a;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (bus.i_busywait == 1'b0) done = 1'b1;
    end
    if (!done) begin
      check("i_timeout", 32'h0, 32'h1);
    end else begin
      check("i_gate", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
      check("i_rdata", bus.i_readdata, ref_mem[a]);
      note_done(1, bus.d_read | bus.d_write, a);
    end
    @(posedge clk); #1;
    bus.i_read = 1'b0;
  endtask

  // ---------------- single-grant vector table ----------------
  typedef struct {
    logic d_rd; logic d_wr; logic i_rd;
    logic [5:0] d_a; logic [5:0] i_a; logic [31:0] d_wd;
    logic exp_rd; logic exp_wr; logic [5:0] exp_a; logic [31:0] exp_wd;
    logic exp_dbw; logic exp_ibw;
  } vec_t;
  vec_t vecs [6];

  initial begin
    bit all_high;
    bit done;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 6'h05, 6'h21, 32'h0,       1'b1, 1'b0, 6'h05, 32'h0,       1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 6'h05, 6'h21, 32'h0,       1'b1, 1'b0, 6'h21, 32'h0,       1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 6'h07, 6'h22, 32'h0,       1'b1, 1'b0, 6'h07, 32'h0,       1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 6'h0A, 6'h22, 32'h11223344, 1'b0, 1'b1, 6'h0A, 32'h11223344, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 6'h0C, 6'h23, 32'h55667788, 1'b0, 1'b1, 6'h0C, 32'h55667788, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 6'h3F, 6'h24, 32'hFFFFFFFF, 1'b0, 1'b0, 6'h0C, 32'h55667788, 1'b0, 1'b0};

    // ---- reset state ----
    do_reset();
    @(negedge clk);
    check("rst_mem_read",  32'(bus.mem_read), 32'h0);
    check("rst_mem_write", 32'(bus.mem_write), 32'h0);
    check("rst_mem_addr",  32'(bus.mem_address), 32'h0);
    check("rst_mem_wdata", bus.mem_writedata, 32'h0);
    check("rst_bw", {30'h0, bus.d_busywait, bus.i_busywait}, 32'h0);
    check("rst_state", 32'(dut.state_r), 32'(IDLE));
    check("rst_rr", 32'(dut.rr_ptr_r), 32'(CLIENT_D));
    @(posedge clk); #1;

    // ---- table: grant then withdraw before memory starts ----
    for (int k = 0; k < 6; k++) begin
      bus.d_read = vecs[k].d_rd; bus.d_write = vecs[k].d_wr; bus.i_read = vecs[k].i_rd;
      bus.d_address = vecs[k].d_a; bus.i_address = vecs[k].i_a; bus.d_writedata = vecs[k].d_wd;
      @(negedge clk);
      check($sformatf("tv%0d_idle_strobe", k), {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
      check($sformatf("tv%0d_idle_bw", k), {30'h0, bus.d_busywait, bus.i_busywait},
            {30'h0, vecs[k].d_rd | vecs[k].d_wr, vecs[k].i_rd});
      @(negedge clk);
      check($sformatf("tv%0d_rd", k), 32'(bus.mem_read), 32'(vecs[k].exp_rd));
      check($sformatf("tv%0d_wr", k), 32'(bus.mem_write), 32'(vecs[k].exp_wr));
      check($sformatf("tv%0d_addr", k), 32'(bus.mem_address), 32'(vecs[k].exp_a));
      check($sformatf("tv%0d_wdata", k), bus.mem_writedata, vecs[k].exp_wd);
      check($sformatf("tv%0d_bw", k), {30'h0, bus.d_busywait, bus.i_busywait},
            {30'h0, vecs[k].exp_dbw, vecs[k].exp_ibw});
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.i_read = 1'b0;
      @(posedge clk); #1;
      check($sformatf("tv%0d_abort_state", k), 32'(dut.state_r), 32'(IDLE));
      check($sformatf("tv%0d_abort_rr", k), 32'(dut.rr_ptr_r), 32'(CLIENT_D));
    end

    // ---- D read at 05 with I idle ----
    do_reset();
    bus.d_read = 1'b1; bus.d_address = 6'h05;
    @(negedge clk);
    check("t2_latency_rd", 32'(bus.mem_read), 32'h0);
    @(negedge clk);
    check("t2_rd", 32'(bus.mem_read), 32'h1);
    check("t2_addr", 32'(bus.mem_address), 32'h05);
    d_txn(1'b1, 1'b0, 6'h05, 32'h0);
    check("t2_rr", 32'(dut.rr_ptr_r), 32'(CLIENT_I));
    check("t2_state", 32'(dut.state_r), 32'(IDLE));

    // ---- D write and I read raised together ----
    do_reset();
    bus.d_write = 1'b1; bus.d_address = 6'h0A; bus.d_writedata = 32'h11223344;
    bus.i_read = 1'b1; bus.i_address = 6'h01;
    all_high = 1'b1; done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (bus.i_busywait !== 1'b1) all_high = 1'b0;
      if (bus.d_busywait == 1'b0) done = 1'b1;
    end
    check("t3_d_done", 32'(done), 32'h1);
    check("t3_i_stalled", 32'(all_high), 32'h1);
    ref_mem[6'h0A] = 32'h11223344;
    note_done(0, 1'b1, 6'h0A);
    @(posedge clk); #1;
    bus.d_write = 1'b0;
    @(negedge clk);
    check("t3_gap_state", 32'(dut.state_r), 32'(IDLE));
    check("t3_gap_ibw", 32'(bus.i_busywait), 32'h1);
    @(negedge clk);
    check("t3_i_grant", 32'(dut.state_r), 32'(GRANT_I));
    check("t3_i_rd", 32'(bus.mem_read), 32'h1);
    check("t3_i_addr", 32'(bus.mem_address), 32'h01);
    i_txn(6'h01);
    check("t3_mem0A", mem_model[6'h0A], 32'h11223344);

    // ---- both request continuously: D, I, D, I ----
    do_reset();
    fork
      begin d_txn(1'b1, 1'b0, 6'h02, 32'h0); d_txn(1'b1, 1'b0, 6'h03, 32'h0); end
      begin i_txn(6'h24); i_txn(6'h25); end
    join
    check("t4_count", 32'(log_id.size()), 32'd4);
    for (int k = 0; k < log_id.size() && k < 4; k++)
      check($sformatf("t4_order%0d", k), 32'(log_id[k]), 32'(k % 2));

    // ---- D write-back then fetch while I waits: D(10), I, D(20) ----
    do_reset();
    fork
      begin d_txn(1'b0, 1'b1, 6'h10, 32'hA1B2C3D4); d_txn(1'b1, 1'b0, 6'h20, 32'h0); end
      begin repeat (2) begin @(posedge clk); #1; end i_txn(6'h30); end
    join
    check("t5_count", 32'(log_addr.size()), 32'd3);
    if (log_addr.size() == 3) begin
      check("t5_a0", 32'(log_addr[0]), 32'h10);
      check("t5_a1", 32'(log_addr[1]), 32'h30);
      check("t5_a2", 32'(log_addr[2]), 32'h20);
    end
    check("t5_mem10", mem_model[6'h10], 32'hA1B2C3D4);

    // ---- reset in the middle of a GRANT_I transaction ----
    do_reset();
    d_txn(1'b1, 1'b0, 6'h03, 32'h0);
    bus.i_read = 1'b1; bus.i_address = 6'h21;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_rd", 32'(bus.mem_read), 32'h0);
    check("t6_state", 32'(dut.state_r), 32'(IDLE));
    check("t6_rr", 32'(dut.rr_ptr_r), 32'(CLIENT_D));
    check("t6_addr", 32'(bus.mem_address), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    expect_next = -1;
    i_txn(6'h21);

    // ---- random traffic against the reference model ----
    do_reset();
    fork
      begin
        for (int t = 0; t < 25; t++) begin
          int gap = int'($urandom_range(0, 3));
          int op  = int'($urandom_range(0, 2));
          repeat (gap) begin @(posedge clk); #1; end
          d_txn(op != 1, op != 0, 6'($urandom_range(0, 31)), $urandom);
        end
      end
      begin
        for (int t = 0; t < 25; t++) begin
          int gap = int'($urandom_range(0, 3));
          repeat (gap) begin @(posedge clk); #1; end
          i_txn(6'($urandom_range(32, 63)));
        end
      end
    join
    check("rand_count", 32'(log_id.size()), 32'd50);
    check("no_dual_strobe", 32'(dual_strobe_seen), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single block-level data memory (6-bit block address, 32-bit block data, busywait handshake) between two cache clients.
  - Client D: data cache.
  - Client I: instruction cache.
- Sits between both caches and the data memory in the top-level testbench/system.
- Round-robin arbitration per memory transaction.
- The grant is held until the memory signals completion; the losing client is stalled via its busywait.

Parameters:
- ADDR_W, 6, memory block address width
- DATA_W, 32, memory block data width

Ports:
- CLK  input  1  system clock, posedge active
- RESET  input  1  asynchronous, active-high reset
- D_READ  input  1  data-cache memory read request
- D_WRITE  input  1  data-cache memory write request
- D_ADDRESS  input  ADDR_W  data-cache block address
- D_WRITEDATA  input  DATA_W  data-cache write block
- D_READDATA  output  DATA_W  read block to data cache
- D_BUSYWAIT  output  1  stall to data cache
- I_READ  input  1  instruction-cache read request (I never writes)
- I_ADDRESS  input  ADDR_W  instruction-cache block address
- I_READDATA  output  DATA_W  read block to instruction cache
- I_BUSYWAIT  output  1  stall to instruction cache
- MEM_READ  output  1  read strobe to memory
- MEM_WRITE  output  1  write strobe to memory
- MEM_ADDRESS  output  ADDR_W  address to memory
- MEM_WRITEDATA  output  DATA_W  write block to memory
- MEM_READDATA  input  DATA_W  block from memory
- MEM_BUSYWAIT  input  1  memory busy

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high.
- Requests:
  - req_D = D_READ | D_WRITE; req_I = I_READ.
  - A client holds its request, address and writedata stable until it samples its busywait low at a posedge.
- State machine (registered, posedge CLK): IDLE, GRANT_D, GRANT_I.
- IDLE:
  - Only one requester → grant it next cycle.
  - Both requesting → grant the client named by the rr_ptr register (0 = D, 1 = I).
  - No request → stay in IDLE.
  - Arbitration latency is one cycle from request to memory strobe.
- GRANT_x:
  - started flag is set at the first posedge with MEM_BUSYWAIT = 1.
  - At a posedge with started = 1 and MEM_BUSYWAIT = 0, the transaction is complete:
    - go to IDLE;
    - clear started;
    - rr_ptr := the other client.
  - If the granted client drops its request before started (abort), go to IDLE without changing rr_ptr.
- Memory side (combinational):
  - IDLE: MEM_READ = MEM_WRITE = 0; MEM_ADDRESS and MEM_WRITEDATA hold their last values.
  - GRANT_D: MEM_* follow the D inputs. If D_READ and D_WRITE are both high, the write wins and MEM_READ = 0.
  - GRANT_I: MEM_READ = I_READ, MEM_WRITE = 0, MEM_ADDRESS = I_ADDRESS.
  - Strobes are additionally gated to 0 once started = 1 and MEM_BUSYWAIT = 0, so a completed request is never re-issued to memory.
- Client side (combinational):
  - x_BUSYWAIT = req_x & ~(state == GRANT_x & started & ~MEM_BUSYWAIT).
  - A requesting, non-granted client sees busywait = 1; a non-requesting client sees 0.
  - D_READDATA and I_READDATA both carry MEM_READDATA; the data is valid only for the grantee at completion.
- Reset (asynchronous, mid-transaction included):
  - state = IDLE, started = 0, rr_ptr = 0 (D favoured).
  - MEM_READ = MEM_WRITE = 0; MEM_ADDRESS and MEM_WRITEDATA = 0.
  - Any in-flight grant is dropped; the client re-arbitrates after RESET falls.
- Back-to-back transactions from the same client (e.g. write-back then fetch) are separate transactions: the client returns to IDLE arbitration between them, so the other client can interleave.

Decomposition:
- Package mem_arbiter_pkg:
  - state encoding constants: IDLE = 2'b00, GRANT_D = 2'b01, GRANT_I = 2'b10;
  - client IDs: CLIENT_D = 1'b0, CLIENT_I = 1'b1.
- Sub-module rr_pick2: combinational two-way round-robin picker.
  - Inputs: req_D, req_I, rr_ptr.
  - Outputs: grant_valid, grant_id.

Test Plan:
- Bench memory model asserts busywait 5 cycles per access.
- Reset then D read at address 6'h05, I idle → MEM_READ = 1 and MEM_ADDRESS = 05 one cycle later; D_BUSYWAIT falls after completion; D_READDATA = 32'hDEADBEEF; rr_ptr = 1.
- D write (address 6'h0A, data 32'h11223344) and I read (address 6'h01) raised in the same cycle with rr_ptr = 0 → D is served first and memory[0A] = 11223344; I_BUSYWAIT stays 1 throughout, then I is granted in the following IDLE cycle.
- Both clients request continuously for 4 transactions → grant order is D, I, D, I; neither client is served twice in a row.
- D issues a write-back to 6'h10, then a fetch from 6'h20 while I is requesting → order is D(10), I, D(20).
- RESET pulsed 2 cycles into a GRANT_I transaction → MEM_READ drops to 0 immediately, state = IDLE, rr_ptr = 0; after release, I re-arbitrates and completes correctly.
- D_READ and D_WRITE both high → only MEM_WRITE is asserted.
